// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcode constants and fetch state encoding shared by fetch and decode
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - request/acknowledge instruction memory port
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch/issue sequencer for the single-cycle core
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   imem,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [ADDR_W-1:0]    branch_target,
    output logic [INSTR_W-1:0]   Instruction,
    output logic [6:0]           Opcode,
    output logic                 instr_valid,
    output logic [ADDR_W-1:0]    PC,
    output logic [31:0]          retired,
    output logic                 halted,
    output logic                 fault
);

    fetch_state_t state;
    logic         req_q;

    // Memory address is always the PC; the request is a registered flag
    assign imem.imem_addr = PC;
    assign imem.imem_req  = req_q;

    // Decoder sees a zero opcode when nothing is presented so it takes its no-op default
    assign Opcode = instr_valid ? Instruction[6:0] : 7'b0000000;

    // Fetch sequencer: all outputs registered, next-PC mux inline on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            PC          <= RESET_PC;
            req_q       <= 1'b0;
            instr_valid <= 1'b0;
            Instruction <= '0;
            retired     <= '0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_q <= 1'b1;
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem.imem_ack) begin
                        Instruction <= imem.imem_rdata;
                        req_q       <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
                        if (Instruction[6:0] == OP_SYSTEM) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                            halted <= 1'b1;
                            fault  <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            PC    <= branch_taken ? branch_target : PC + ADDR_W'(4);
                            req_q <= 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [31:0] I_ADDI1 = 32'h00100093;
    localparam logic [31:0] I_ADDI2 = 32'h00200113;
    localparam logic [31:0] I_ADDI3 = 32'h00300193;
    localparam logic [31:0] I_ADDI4 = 32'h00400213;
    localparam logic [31:0] I_BEQ   = 32'h00000463;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               stall = 1'b0;
    logic               branch_taken = 1'b0;
    logic [ADDR_W-1:0]  branch_target = '0;
    logic [INSTR_W-1:0] Instruction;
    logic [6:0]         Opcode;
    logic               instr_valid;
    logic [ADDR_W-1:0]  PC;
    logic [31:0]        retired;
    logic               halted;
    logic               fault;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem ();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .Instruction   (Instruction),
        .Opcode        (Opcode),
        .instr_valid   (instr_valid),
        .PC            (PC),
        .retired       (retired),
        .halted        (halted),
        .fault         (fault)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc[$];
    logic [31:0] mem[logic [63:0]];
    int          stall_tbl[logic [63:0]];
    logic        br_tbl[logic [63:0]];
    logic [63:0] tgt_tbl[logic [63:0]];
    int          latency = 0;
    bit          force_ack = 1'b0;
    int          wait_cnt = 0;
    int          stall_left = 0;
    bit          prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic [31:0] instr, input logic [31:0] ret);
        exp_t e;
        e.pc = pc; e.instr = instr; e.ret = ret;
        exp_q.push_back(e);
    endtask

    // Memory model: acks after `latency` waiting cycles, or unconditionally when forced
    always @(negedge clk) begin
        #2;
        if (force_ack) begin
            imem.imem_ack   = 1'b1;
            imem.imem_rdata = I_ECALL;
        end else if (imem.imem_req) begin
            if (wait_cnt >= latency) begin
                imem.imem_ack   = 1'b1;
                imem.imem_rdata = mem.exists(imem.imem_addr) ? mem[imem.imem_addr] : 32'h00000013;
                wait_cnt        = 0;
            end else begin
                imem.imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem.imem_ack = 1'b0;
            wait_cnt      = 0;
        end
    end

    // Datapath model: stalls and branch outcome per address; junk outside the accept cycle
    always @(negedge clk) begin
        if (instr_valid && !prev_valid)
            stall_left = stall_tbl.exists(PC) ? stall_tbl[PC] : 0;
        prev_valid = instr_valid;
        if (instr_valid && stall_left == 0) begin
            stall         = 1'b0;
            branch_taken  = br_tbl.exists(PC) ? br_tbl[PC] : 1'b0;
            branch_target = tgt_tbl.exists(PC) ? tgt_tbl[PC] : 64'h0;
        end else begin
            if (instr_valid) stall_left--;
            stall         = 1'b1;
            branch_taken  = 1'b1;
            branch_target = 64'h42;
        end
    end

    // Monitor: compares every presented instruction with the scoreboard head, pops on accept
    always @(negedge clk) begin
        #1;
        cyc++;
        if (!instr_valid) begin
            if (rst_n) check("opcode_gated", Opcode, 7'd0);
        end else if (exp_q.size() == 0) begin
            check("unexpected_issue", PC, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            mon_e = exp_q[0];
            check("issue_pc", PC, mon_e.pc);
            check("issue_addr", imem.imem_addr, mon_e.pc);
            check("issue_instr", Instruction, mon_e.instr);
            check("issue_opcode", Opcode, mon_e.instr[6:0]);
            check("issue_retired", retired, mon_e.ret);
            if (!stall) begin
                void'(exp_q.pop_front());
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_tables();
        mem.delete(); stall_tbl.delete(); br_tbl.delete(); tgt_tbl.delete();
        exp_q.delete(); acc_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        #3;
        check("halt_reached", halted, 1'b1);
    endtask

    task automatic end_checks(input string tag, input logic [63:0] pc, input logic [31:0] ret, input logic flt);
        check({tag, "_pc"}, PC, pc);
        check({tag, "_retired"}, retired, ret);
        check({tag, "_fault"}, fault, flt);
        check({tag, "_req_low"}, imem.imem_req, 1'b0);
        check({tag, "_valid_low"}, instr_valid, 1'b0);
        check({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;

        // Reset values
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk); #3;
        check("rst_pc", PC, 64'h0);
        check("rst_req", imem.imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_opcode", Opcode, 7'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 1'b0);

        // Sequential fetch, zero wait
        clear_tables();
        latency = 0;
        mem[64'h0] = I_ADDI1; mem[64'h4] = I_ADDI2; mem[64'h8] = I_ADDI3; mem[64'hC] = I_ECALL;
        push_exp(64'h0, I_ADDI1, 0); push_exp(64'h4, I_ADDI2, 1);
        push_exp(64'h8, I_ADDI3, 2); push_exp(64'hC, I_ECALL, 3);
        do_reset();
        wait_halt(100);
        end_checks("seq", 64'hC, 32'd4, 1'b0);
        check("seq_accepts", acc_cyc.size(), 4);
        for (int i = 0; i + 1 < acc_cyc.size() && i < 3; i++)
            check("seq_issue_spacing", acc_cyc[i+1] - acc_cyc[i], 2);

        // Wait states: ack on the fourth request cycle
        clear_tables();
        latency = 3;
        mem[64'h0] = I_ADDI1; mem[64'h4] = I_ECALL;
        push_exp(64'h0, I_ADDI1, 0); push_exp(64'h4, I_ECALL, 1);
        do_reset();
        #3;
        n = 0;
        while (!imem.imem_req && n < 10) begin @(negedge clk); #3; n++; end
        check("ws_req_seen", imem.imem_req, 1'b1);
        n = 0;
        while (imem.imem_req && !instr_valid && n < 20) begin
            check("ws_addr_stable", imem.imem_addr, 64'h0);
            n++;
            @(negedge clk); #3;
        end
        check("ws_req_cycles", n, 4);
        check("ws_valid_after_ack", instr_valid, 1'b1);
        wait_halt(100);
        end_checks("ws", 64'h4, 32'd2, 1'b0);

        // Taken branch at 0x10 to 0x40, stalled for two issue cycles first
        clear_tables();
        latency = 0;
        mem[64'h0] = I_ADDI1; mem[64'h4] = I_ADDI2; mem[64'h8] = I_ADDI3; mem[64'hC] = I_ADDI4;
        mem[64'h10] = I_BEQ; mem[64'h40] = I_ECALL;
        stall_tbl[64'h10] = 2; br_tbl[64'h10] = 1'b1; tgt_tbl[64'h10] = 64'h40;
        push_exp(64'h0, I_ADDI1, 0); push_exp(64'h4, I_ADDI2, 1); push_exp(64'h8, I_ADDI3, 2);
        push_exp(64'hC, I_ADDI4, 3); push_exp(64'h10, I_BEQ, 4); push_exp(64'h40, I_ECALL, 5);
        do_reset();
        wait_halt(200);
        end_checks("br_taken", 64'h40, 32'd6, 1'b0);
        check("stall_accepts", acc_cyc.size(), 6);
        if (acc_cyc.size() >= 5) check("stall_accept_third", acc_cyc[4] - acc_cyc[3], 4);

        // Not-taken branch at 0x10 falls through to 0x14
        clear_tables();
        mem[64'h0] = I_ADDI1; mem[64'h4] = I_ADDI2; mem[64'h8] = I_ADDI3; mem[64'hC] = I_ADDI4;
        mem[64'h10] = I_BEQ; mem[64'h14] = I_ECALL; mem[64'h40] = I_ADDI1;
        br_tbl[64'h10] = 1'b0; tgt_tbl[64'h10] = 64'h40;
        push_exp(64'h0, I_ADDI1, 0); push_exp(64'h4, I_ADDI2, 1); push_exp(64'h8, I_ADDI3, 2);
        push_exp(64'hC, I_ADDI4, 3); push_exp(64'h10, I_BEQ, 4); push_exp(64'h14, I_ECALL, 5);
        do_reset();
        wait_halt(200);
        end_checks("br_not_taken", 64'h14, 32'd6, 1'b0);

        // Misaligned branch target halts with fault
        clear_tables();
        mem[64'h0] = I_BEQ;
        br_tbl[64'h0] = 1'b1; tgt_tbl[64'h0] = 64'h42;
        push_exp(64'h0, I_BEQ, 0);
        do_reset();
        wait_halt(100);
        end_checks("misalign", 64'h0, 32'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #3;
            check("misalign_req_stays_low", imem.imem_req, 1'b0);
        end
        check("misalign_still_halted", halted, 1'b1);

        // Reset during a fetch whose ack lands on the reset edge, then a stray ack in IDLE
        clear_tables();
        latency = 1;
        mem[64'h0] = I_ADDI1; mem[64'h4] = I_ADDI2; mem[64'h8] = I_ECALL;
        push_exp(64'h0, I_ADDI1, 0);
        do_reset();
        #3;
        n = 0;
        while (!(exp_q.size() == 0 && imem.imem_req && imem.imem_addr == 64'h4) && n < 50) begin
            @(negedge clk); #3; n++;
        end
        check("rmf_second_fetch", imem.imem_addr, 64'h4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        force_ack = 1'b1;
        #3;
        check("rmf_req", imem.imem_req, 1'b0);
        check("rmf_pc", PC, 64'h0);
        check("rmf_retired", retired, 32'd0);
        check("rmf_valid", instr_valid, 1'b0);
        check("rmf_halted", halted, 1'b0);
        push_exp(64'h0, I_ADDI1, 0); push_exp(64'h4, I_ADDI2, 1); push_exp(64'h8, I_ECALL, 2);
        @(negedge clk);
        force_ack = 1'b0;
        wait_halt(100);
        end_checks("rmf", 64'h8, 32'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer that produces the instruction stream (and the 7-bit `Opcode`) consumed by the control unit and datapath of the single-cycle RISC-V core. It owns the program counter, performs a request/acknowledge fetch from instruction memory, presents one instruction at a time with a valid flag, and advances the PC sequentially or to a resolved branch target. It halts on a SYSTEM opcode or a misaligned target.

## Interface

- `ADDR_W`, 64, PC / instruction-memory address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `imem_req`  out  1  fetch request, held until `imem_ack`
- `imem_addr`  out  ADDR_W  fetch address, equal to `PC`
- `imem_ack`  in  1  fetch data valid on `imem_rdata` this cycle
- `imem_rdata`  in  INSTR_W  fetched instruction
- `stall`  in  1  datapath cannot accept the presented instruction
- `branch_taken`  in  1  resolved branch/jump outcome for the presented instruction
- `branch_target`  in  ADDR_W  target address when `branch_taken`
- `Instruction`  out  INSTR_W  presented instruction
- `Opcode`  out  7  `Instruction[6:0]` when `instr_valid`, else 7'b0000000
- `instr_valid`  out  1  `Instruction` is valid for the datapath
- `PC`  out  ADDR_W  address of the presented/fetching instruction
- `retired`  out  32  count of accepted instructions
- `halted`  out  1  fetch stopped
- `fault`  out  1  stopped on a misaligned target

## Operation

- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: entered on reset; next cycle goes to FETCH unconditionally.
- FETCH: `imem_req`=1, `imem_addr`=`PC`. On `imem_ack`, capture `imem_rdata` into the instruction register → ISSUE. Without an ack, stay, with request and address stable.
- ISSUE: `instr_valid`=1, `Instruction` held. Accept = `instr_valid && !stall`. On accept:
  - `retired` += 1, wrapping modulo 2^32.
  - Opcode 7'b1110011 (SYSTEM) → HALT, `PC` unchanged.
  - Else if `branch_taken` and `branch_target[1:0]` != 0 → HALT, `fault`=1, `PC` unchanged.
  - Else `PC` ← `branch_taken` ? `branch_target` : `PC`+4, modulo 2^ADDR_W. Then → FETCH.
- `stall` high in ISSUE: hold everything. `branch_*` is ignored until the accept cycle.
- HALT: `halted`=1, `imem_req`=0, `instr_valid`=0. Leave only through reset.
- A zero `Opcode` while not valid makes the control unit fall to its default case, with no register or memory writes.
- `imem_ack` outside FETCH is ignored.
- `stall` and `branch_*` outside ISSUE are ignored.

## Timing

- Reset values: state IDLE, `PC`=`RESET_PC`, `imem_req`=0, `instr_valid`=0, `Instruction`=0, `Opcode`=0, `retired`=0, `halted`=0, `fault`=0.
- `rst_n` low at any cycle, including mid-fetch or mid-issue: all registers take reset values at that edge. An outstanding ack is dropped.
- `imem_ack` may arrive in the same cycle `imem_req` rises (zero wait). Minimum cost is 2 cycles per instruction: FETCH, then ISSUE.
- `instr_valid` rises the cycle after the ack cycle.
- The PC update is visible on `imem_addr` the cycle after accept.
- All outputs are registered except `Opcode`, which is a gated slice of the registered `Instruction`.

## Structure

- Shared package `riscv_pkg`:
  - opcode constants `OP_RTYPE` 0110011, `OP_LOAD` 0000011, `OP_STORE` 0100011, `OP_IMM` 0010011, `OP_BRANCH` 1100011, `OP_SYSTEM` 1110011
  - fetch state enum
- These are shared with the control unit decoder.
- Single module. No sub-module needed; the next-PC mux stays inline.

## Test plan

- Sequential fetch: reset with `RESET_PC`=0, ack in the same cycle as req, memory returns addi at 0x0/0x4/0x8.
  → `imem_addr` 0x0, 0x4, 0x8.
  → `instr_valid` every second cycle, `Opcode`=0010011, `retired`=3.
- Wait states: ack 3 cycles after req.
  → `imem_req` and `imem_addr` stable for 4 cycles.
  → `instr_valid` rises exactly one cycle after ack.
- Branch: beq at 0x10 with `branch_taken`=1, target 0x40 → next `imem_addr`=0x40. Repeat with `branch_taken`=0 → next address 0x14.
- Stall: `stall`=1 for 2 ISSUE cycles.
  → `Instruction`, `PC` and `retired` unchanged.
  → Accept on the third cycle, `retired`+1.
- Halt paths:
  - Branch target 0x42 → `halted`=1, `fault`=1, `imem_req` stays 0.
  - Instruction 0x00000073 → `halted`=1, `fault`=0, `PC` unchanged.
- Reset mid-fetch: `rst_n` low during FETCH with a pending ack.
  → Next cycle `imem_req`=0, `PC`=`RESET_PC`, `retired`=0.
  → A late ack is ignored.
